// File: rtl/sum_group_accumulator.sv
// Reduces a stream of sums to one registered total per group of n_items consecutive sums.
// Optional SUM_GROUP_ACC_LAST_EN adds up_last (early group close) and down_cnt (items in group).
module sum_group_accumulator #(
  parameter int unsigned in_width  = 9,
  parameter int unsigned n_items   = 4,  // legal range 2..256
  parameter int unsigned out_width = in_width + $clog2(n_items)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up_vld,
  output logic                          up_rdy,
  input  logic [in_width-1:0]           up_data,
`ifdef SUM_GROUP_ACC_LAST_EN
  input  logic                          up_last,
  output logic [$clog2(n_items+1)-1:0]  down_cnt,
`endif
  output logic                          down_vld,
  input  logic                          down_rdy,
  output logic [out_width-1:0]          down_data
);

  localparam int unsigned CntW  = ($clog2(n_items) > 1) ? $clog2(n_items) : 1;
  localparam int unsigned DCntW = $clog2(n_items + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(n_items - 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e               state_q, state_d;
  logic [out_width-1:0] acc_q, acc_d;
  logic [out_width-1:0] total_q, total_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DCntW-1:0]     dcnt_q, dcnt_d;
  logic [out_width-1:0] sum;
  logic                 up_fire;
  logic                 close_grp;

  // The only combinational path to an output is down_rdy -> up_rdy.
  assign up_rdy    = (state_q == StAccum) | down_rdy;
  assign up_fire   = up_vld & up_rdy;
  assign sum       = acc_q + out_width'(up_data);
  assign down_vld  = (state_q == StHold);
  assign down_data = total_q;

`ifdef SUM_GROUP_ACC_LAST_EN
  assign close_grp = (cnt_q == LastIdx) | up_last;
  assign down_cnt  = dcnt_q;
`else
  assign close_grp = (cnt_q == LastIdx);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    dcnt_d  = dcnt_q;
    // acc/cnt are cleared when a group closes, so a sum accepted in StHold
    // naturally lands as item 0 of the next group.
    if (up_fire) begin
      if (close_grp) begin
        total_d = sum;
        dcnt_d  = DCntW'(cnt_q) + DCntW'(1);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StHold;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_q + CntW'(1);
        state_d = StAccum;
      end
    end else if ((state_q == StHold) && down_rdy) begin
      state_d = StAccum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      total_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      dcnt_q  <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_sum_group_accumulator.sv
// Directed and random checks of sum_group_accumulator against a queue-based group model.
module tb_sum_group_accumulator;

  localparam int unsigned IW = 9;
  localparam int unsigned N  = 4;
  localparam int unsigned OW = IW + $clog2(N);
`ifdef SUM_GROUP_ACC_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          up_vld;
  logic          up_rdy;
  logic [IW-1:0] up_data;
  logic          down_vld;
  logic          down_rdy;
  logic [OW-1:0] down_data;
`ifdef SUM_GROUP_ACC_LAST_EN
  logic                   up_last;
  logic [$clog2(N+1)-1:0] down_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference: items of the open group, plus the presented total (if any).
  int unsigned m_q[$];
  bit          m_have = 1'b0;
  int unsigned m_out  = 0;
  int unsigned m_cnt  = 0;

  always #5 clk = ~clk;

  sum_group_accumulator #(
    .in_width (IW),
    .n_items  (N),
    .out_width(OW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .up_vld   (up_vld),
    .up_rdy   (up_rdy),
    .up_data  (up_data),
`ifdef SUM_GROUP_ACC_LAST_EN
    .up_last  (up_last),
    .down_cnt (down_cnt),
`endif
    .down_vld (down_vld),
    .down_rdy (down_rdy),
    .down_data(down_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit r, input bit v, input int unsigned d, input bit dr, input bit l);
    bit          exp_rdy;
    bit          fire_up;
    int unsigned s;
    @(posedge clk);
    #1;
    rst      = r;
    up_vld   = v;
    up_data  = IW'(d);
    down_rdy = dr;
`ifdef SUM_GROUP_ACC_LAST_EN
    up_last  = l;
`endif
    #3;
    exp_rdy = !m_have || dr;
    check("up_rdy", {31'd0, up_rdy}, {31'd0, exp_rdy});
    check("down_vld", {31'd0, down_vld}, {31'd0, m_have});
    if (m_have) begin
      check("down_data", 32'(down_data), m_out);
`ifdef SUM_GROUP_ACC_LAST_EN
      check("down_cnt", 32'(down_cnt), m_cnt);
`endif
    end
    if (r) begin
      m_q.delete();
      m_have = 1'b0;
      m_out  = 0;
      m_cnt  = 0;
    end else begin
      fire_up = v && exp_rdy;
      if (m_have && dr) m_have = 1'b0;
      if (fire_up) begin
        m_q.push_back(d);
        if (m_q.size() == N || (LastEn && l)) begin
          s = 0;
          foreach (m_q[i]) s += m_q[i];
          m_out  = s;
          m_cnt  = m_q.size();
          m_have = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    up_vld   = 1'b0;
    up_data  = '0;
    down_rdy = 1'b0;
`ifdef SUM_GROUP_ACC_LAST_EN
    up_last  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_down_vld", {31'd0, down_vld}, 32'd0);
    check("rst_down_data", 32'(down_data), 32'd0);
    check("rst_up_rdy", {31'd0, up_rdy}, 32'd1);

    // 10+20+30+40, one cycle after the last handshake
    step(0, 1, 10, 1, 0);
    step(0, 1, 20, 1, 0);
    step(0, 1, 30, 1, 0);
    step(0, 1, 40, 1, 0);
    step(0, 0, 0, 1, 0);
    check("t100_vld", {31'd0, down_vld}, 32'd1);
    check("t100_data", 32'(down_data), 32'd100);
    step(0, 0, 0, 1, 0);
    check("t100_single", {31'd0, down_vld}, 32'd0);

    // Maximum operands
    repeat (4) step(0, 1, 511, 1, 0);
    step(0, 0, 0, 1, 0);
    check("max_data", 32'(down_data), 32'd2044);

    // Backpressure with the next group pending
    step(0, 1, 1, 1, 0);
    step(0, 1, 2, 1, 0);
    step(0, 1, 3, 1, 0);
    step(0, 1, 4, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 5, 0, 0);
      check("hold_data", 32'(down_data), 32'd10);
      check("hold_up_rdy", {31'd0, up_rdy}, 32'd0);
    end
    step(0, 1, 5, 1, 0);
    check("release_up_rdy", {31'd0, up_rdy}, 32'd1);
    step(0, 1, 6, 1, 0);
    step(0, 1, 7, 1, 0);
    step(0, 1, 8, 1, 0);
    step(0, 0, 0, 1, 0);
    check("t26_data", 32'(down_data), 32'd26);

    // Continuous stream of ones
    for (int i = 0; i < 12; i++) step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    check("ones_data", 32'(down_data), 32'd4);

    // Reset drops a partial group
    step(0, 1, 7, 1, 0);
    step(0, 1, 7, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("rst2_down_vld", {31'd0, down_vld}, 32'd0);
    repeat (4) step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    check("after_rst_data", 32'(down_data), 32'd4);
    step(0, 0, 0, 1, 0);

`ifdef SUM_GROUP_ACC_LAST_EN
    step(0, 1, 5, 1, 0);
    step(0, 1, 7, 1, 1);
    step(0, 0, 0, 1, 0);
    check("last_data", 32'(down_data), 32'd12);
    check("last_cnt", 32'(down_cnt), 32'd2);
    repeat (4) step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    check("full_data", 32'(down_data), 32'd4);
    check("full_cnt", 32'(down_cnt), 32'd4);
    step(0, 0, 0, 1, 0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 511),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end
    repeat (4) step(0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
